hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (F/D/E/M/W). Branches and jumps resolve in D.
- Takes register-use info from D, producer info from E/M, memory busy flags and the commit-stage redirect. Produces per-stage stall/flush controls.
- Owns a multi-cycle mul/div occupancy FSM and a wrong-path fetch drop latch.
- Replaces ad-hoc combinational stall logic scattered across stages.

---
 rtl/hazard_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Central pipeline stall/flush sequencer: mul/div occupancy FSM, wrong-path fetch drop latch.
// Optional performance counters are enabled with the HAZARD_PERF_EN macro.
module hazard_ctrl #(
    parameter int unsigned MULDIV_LAT = 32,
    parameter int unsigned REG_AW     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic              use_rs1_d,
    input  logic              use_rs2_d,
    input  logic              branch_d,
    input  logic              redirect_d,
    input  logic              wr_e,
    input  logic              ld_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              ld_m,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              muldiv_e,
    input  logic              imem_busy,
    input  logic              dmem_busy,
    input  logic              exc_w,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              flush_w,
    output logic              exc_ack,
    output logic              muldiv_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_ld_stall,
    output logic [31:0]       perf_md_stall,
    output logic [31:0]       perf_mem_stall,
    output logic [31:0]       perf_redirect
`endif
);

    localparam int unsigned CW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [CW-1:0] CntInit = CW'(MULDIV_LAT - 1);

    typedef enum logic {StIdle, StBusy} md_state_e;

    md_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        drop_pend_q, drop_pend_d;

    logic match_e, match_m;
    logic md_start, md_stall, ld_hz;
    logic exc_take, md_act, ld_act;
    logic redirect_take, drop_clear, drop_set;

    // Register 0 never creates a dependency.
    always_comb begin
        match_e = (rd_e != '0) &&
                  ((use_rs1_d && (rs1_d == rd_e)) || (use_rs2_d && (rs2_d == rd_e)));
        match_m = (rd_m != '0) &&
                  ((use_rs1_d && (rs1_d == rd_m)) || (use_rs2_d && (rs2_d == rd_m)));
        ld_hz   = (ld_e && match_e) || (branch_d && wr_e && match_e) ||
                  (branch_d && ld_m && match_m);
    end

    always_comb begin
        md_start = (state_q == StIdle) && muldiv_e && !exc_w;
        md_stall = md_start || ((state_q == StBusy) && (cnt_q != '0));
        exc_take = exc_w && !dmem_busy;
        md_act   = !dmem_busy && !exc_w && md_stall;
        ld_act   = !dmem_busy && !exc_w && !md_stall && ld_hz;
    end

    always_comb begin
        stall_f       = 1'b0;
        stall_d       = 1'b0;
        stall_e       = 1'b0;
        stall_m       = 1'b0;
        flush_d       = 1'b0;
        flush_e       = 1'b0;
        flush_m       = 1'b0;
        flush_w       = 1'b0;
        exc_ack       = 1'b0;
        redirect_take = 1'b0;
        drop_clear    = 1'b0;

        if (dmem_busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (exc_w) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
            exc_ack = 1'b1;
        end else begin
            if (md_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_m = 1'b1;
            end else if (ld_hz) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
            // A fetch bubble is only needed when D is free to advance.
            if (imem_busy) begin
                stall_f = 1'b1;
                if (!stall_d) begin
                    flush_d = 1'b1;
                end
            end
            if (redirect_d && !stall_d) begin
                redirect_take = 1'b1;
                flush_d       = 1'b1;
            end
        end

        // Discard the fetch that was in flight when control flow changed.
        if (drop_pend_q && !imem_busy && !dmem_busy) begin
            drop_clear = 1'b1;
            flush_d    = 1'b1;
        end
    end

    assign muldiv_busy = (state_q == StBusy);

    always_comb begin
        drop_set    = imem_busy && (exc_take || redirect_take);
        drop_pend_d = drop_pend_q;
        if (drop_set) begin
            drop_pend_d = 1'b1;
        end else if (drop_clear) begin
            drop_pend_d = 1'b0;
        end
    end

    // The FSM keeps counting under dmem_busy; only an accepted exception aborts the op.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (exc_take) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (md_start) begin
                        state_d = StBusy;
                        cnt_d   = CntInit;
                    end
                end
                StBusy: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            drop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drop_pend_q <= drop_pend_d;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ld_stall  <= '0;
            perf_md_stall  <= '0;
            perf_mem_stall <= '0;
            perf_redirect  <= '0;
        end else begin
            if (ld_act) begin
                perf_ld_stall <= perf_ld_stall + 32'd1;
            end
            if (md_act) begin
                perf_md_stall <= perf_md_stall + 32'd1;
            end
            if (dmem_busy) begin
                perf_mem_stall <= perf_mem_stall + 32'd1;
            end
            perf_redirect <= perf_redirect + 32'(redirect_take) + 32'(exc_take);
        end
    end
`else
    logic unused_act;
    assign unused_act = md_act ^ ld_act;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int unsigned LAT = 5;
    localparam int unsigned AW  = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rs1_d, rs2_d, rd_e, rd_m;
    logic          use_rs1_d, use_rs2_d, branch_d, redirect_d;
    logic          wr_e, ld_e, ld_m, muldiv_e, imem_busy, dmem_busy, exc_w;
    logic          stall_f, stall_d, stall_e, stall_m;
    logic          flush_d, flush_e, flush_m, flush_w, exc_ack, muldiv_busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MULDIV_LAT(LAT),
        .REG_AW    (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rs1_d      (rs1_d),
        .rs2_d      (rs2_d),
        .use_rs1_d  (use_rs1_d),
        .use_rs2_d  (use_rs2_d),
        .branch_d   (branch_d),
        .redirect_d (redirect_d),
        .wr_e       (wr_e),
        .ld_e       (ld_e),
        .rd_e       (rd_e),
        .ld_m       (ld_m),
        .rd_m       (rd_m),
        .muldiv_e   (muldiv_e),
        .imem_busy  (imem_busy),
        .dmem_busy  (dmem_busy),
        .exc_w      (exc_w),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .stall_e    (stall_e),
        .stall_m    (stall_m),
        .flush_d    (flush_d),
        .flush_e    (flush_e),
        .flush_m    (flush_m),
        .flush_w    (flush_w),
        .exc_ack    (exc_ack),
        .muldiv_busy(muldiv_busy)
    );

    // {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_m,flush_w,exc_ack,muldiv_busy}
    logic [9:0] act;
    assign act = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
                  exc_ack, muldiv_busy};

    // Reference model: an op is "on" once started; md_done counts stall cycles already spent.
    bit          md_on = 1'b0;
    int unsigned md_done = 0;
    bit          drop = 1'b0;
    logic [9:0]  m_exp;
    logic        m_match_e, m_match_m, m_md, m_hz, m_exc, m_redir;

    always_comb begin
        m_exp     = '0;
        m_exc     = 1'b0;
        m_redir   = 1'b0;
        m_match_e = (rd_e != '0) &&
                    ((use_rs1_d && rs1_d == rd_e) || (use_rs2_d && rs2_d == rd_e));
        m_match_m = (rd_m != '0) &&
                    ((use_rs1_d && rs1_d == rd_m) || (use_rs2_d && rs2_d == rd_m));
        m_md      = md_on ? (md_done < LAT) : (muldiv_e && !exc_w);
        m_hz      = (ld_e && m_match_e) || (branch_d && wr_e && m_match_e) ||
                    (branch_d && ld_m && m_match_m);
        if (dmem_busy) begin
            m_exp = 10'b1111_0001_00;
        end else if (exc_w) begin
            m_exp = 10'b0000_1110_10;
            m_exc = 1'b1;
        end else if (m_md) begin
            m_exp = imem_busy ? 10'b1110_0010_00 : 10'b1110_0010_00;
        end else if (m_hz) begin
            m_exp = 10'b1100_0100_00;
        end else if (imem_busy) begin
            m_exp = 10'b1000_1000_00;
        end
        m_redir = redirect_d && !m_exp[8] && !dmem_busy;
        if (m_redir) m_exp[5] = 1'b1;
        if (drop && !imem_busy && !dmem_busy) m_exp[5] = 1'b1;
        m_exp[0] = md_on;
    end

    always @(posedge clk) begin
        if (reset) begin
            md_on   <= 1'b0;
            md_done <= 0;
            drop    <= 1'b0;
        end else begin
            if (!dmem_busy && exc_w) begin
                md_on   <= 1'b0;
                md_done <= 0;
            end else if (md_on) begin
                if (md_done < LAT) begin
                    md_done <= md_done + 1;
                end else begin
                    md_on   <= 1'b0;
                    md_done <= 0;
                end
            end else if (muldiv_e && !exc_w) begin
                md_on   <= 1'b1;
                md_done <= 1;
            end
            if (imem_busy && (m_exc || m_redir)) begin
                drop <= 1'b1;
            end else if (drop && !imem_busy && !dmem_busy) begin
                drop <= 1'b0;
            end
        end
    end

    task automatic clear_inputs();
        rs1_d = '0; rs2_d = '0; rd_e = '0; rd_m = '0;
        use_rs1_d = 0; use_rs2_d = 0; branch_d = 0; redirect_d = 0;
        wr_e = 0; ld_e = 0; ld_m = 0; muldiv_e = 0;
        imem_busy = 0; dmem_busy = 0; exc_w = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (act !== 10'b0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d act=%b exp=%b", i, act, 10'b0);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        logic [9:0] want [4] = '{10'b1100_0100_00, 10'b0, 10'b0, 10'b1100_0100_00};
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            case (i)
                0: begin ld_e = 1; rd_e = 5'd5; rs1_d = 5'd5; use_rs1_d = 1; end
                1: begin rd_e = 5'd5; rs1_d = 5'd5; use_rs1_d = 1; end
                2: begin ld_e = 1; rd_e = 5'd0; rs1_d = 5'd0; use_rs1_d = 1; end
                3: begin branch_d = 1; wr_e = 1; rd_e = 5'd7; rs2_d = 5'd7; use_rs2_d = 1; end
                default: begin branch_d = 1; ld_m = 1; rd_m = 5'd3; rs1_d = 5'd3; use_rs1_d = 1; end
            endcase
            @(negedge clk);
            checks++;
            if (act !== ((i < 4) ? want[i] : 10'b1100_0100_00) || act !== m_exp) begin
                failures++;
                $display("FAIL load_use case=%0d act=%b exp=%b", i, act, m_exp);
            end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_muldiv();
        clear_inputs();
        for (int i = 0; i < 2 * (LAT + 1); i++) begin
            muldiv_e = 1;
            @(negedge clk);
            checks++;
            if (stall_e !== ((i % (LAT + 1)) != LAT) ||
                muldiv_busy !== ((i % (LAT + 1)) != 0) || act !== m_exp) begin
                failures++;
                $display("FAIL muldiv_hold cyc=%0d act=%b exp=%b", i, act, m_exp);
            end
            @(posedge clk); #1;
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (act !== 10'b0) begin
            failures++;
            $display("FAIL muldiv_idle act=%b exp=%b", act, 10'b0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_redirect();
        logic [9:0] want [5] = '{10'b1000_1000_00, 10'b1000_1000_00, 10'b1000_1000_00,
                                 10'b0000_1000_00, 10'b0};
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            redirect_d = (i == 0);
            imem_busy  = (i < 3);
            @(negedge clk);
            checks++;
            if (act !== want[i] || act !== m_exp) begin
                failures++;
                $display("FAIL redirect_drop cyc=%0d act=%b exp=%b", i, act, want[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_exc_muldiv();
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            muldiv_e = 1;
            exc_w    = (i == 3);
            @(negedge clk);
            checks++;
            if ((i == 3 && act !== 10'b0000_1110_11) ||
                (i == 4 && act !== 10'b1110_0010_00) || act !== m_exp) begin
                failures++;
                $display("FAIL exc_abort cyc=%0d act=%b exp=%b", i, act, m_exp);
            end
            if (i == 4) muldiv_e = 0;
            @(posedge clk); #1;
        end
        clear_inputs();
        // Op restarted after the abort; let it run out.
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            checks++;
            if (act !== m_exp) begin
                failures++;
                $display("FAIL exc_drain cyc=%0d act=%b exp=%b", i, act, m_exp);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (muldiv_busy !== 1'b0) begin
            failures++;
            $display("FAIL exc_idle act=%b exp=0", muldiv_busy);
        end
    endtask

    task automatic test_dmem_priority();
        logic [9:0] want [4] = '{10'b1111_0001_00, 10'b1111_0001_00, 10'b0000_1110_10, 10'b0};
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            dmem_busy = (i < 2);
            exc_w     = (i < 3);
            ld_e = (i < 3); rd_e = 5'd9; rs1_d = 5'd9; use_rs1_d = (i < 3);
            @(negedge clk);
            checks++;
            if (act !== want[i] || act !== m_exp) begin
                failures++;
                $display("FAIL dmem_priority cyc=%0d act=%b exp=%b", i, act, want[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 299) == 0);
            rs1_d      = AW'($urandom_range(0, 3));
            rs2_d      = AW'($urandom_range(0, 3));
            rd_e       = AW'($urandom_range(0, 3));
            rd_m       = AW'($urandom_range(0, 3));
            use_rs1_d  = ($urandom_range(0, 1) == 1);
            use_rs2_d  = ($urandom_range(0, 1) == 1);
            branch_d   = ($urandom_range(0, 3) == 0);
            redirect_d = ($urandom_range(0, 3) == 0);
            wr_e       = ($urandom_range(0, 1) == 1);
            ld_e       = ($urandom_range(0, 3) == 0);
            ld_m       = ($urandom_range(0, 3) == 0);
            muldiv_e   = ($urandom_range(0, 4) == 0);
            imem_busy  = ($urandom_range(0, 2) == 0);
            dmem_busy  = ($urandom_range(0, 6) == 0);
            exc_w      = ($urandom_range(0, 11) == 0);
            @(negedge clk);
            checks++;
            if (act !== m_exp) begin
                failures++;
                $display("FAIL random cyc=%0d act=%b exp=%b", i, act, m_exp);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_muldiv();
        test_redirect();
        test_exc_muldiv();
        test_dmem_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
